random_range_sampler: RTL and testbench

Converts the free-running LFSR word from `random_number_generator` into a uniformly distributed integer in `[0, limit-1]` on request. It sits directly downstream of the generator and upstream of game logic that needs bounded random picks (cell index, delay, colour). Uniformity comes from mask-and-reject sampling with a bounded retry count and a deterministic fallback, so every request completes in bounded time.

---
 rtl/random_range_sampler.sv | 169 ++++++++++++++++
 tb/tb_random_range_sampler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/random_range_sampler.sv
`default_nettype none
// ============================================================================
// Module      : random_range_sampler
// Description : Turns a free-running LFSR word into a uniformly distributed
//               integer in [0, limit-1] using mask-and-reject sampling with a
//               bounded number of tries and a deterministic fold-down fallback.
//               Optional feature macro: RANGE_SAMPLER_NO_REPEAT_EN
//               (reject / nudge a result equal to the previous output).
// Revision    : 1.0 - initial release
// ============================================================================
module random_range_sampler #(
    parameter int RAND_BITS = 32,
    parameter int WIDTH     = 8,
    parameter int MAX_TRIES = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [RAND_BITS-1:0] random_i,
    input  logic                 req_i,
    input  logic [WIDTH-1:0]     limit_i,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     value_o
);

    localparam int               CNT_W      = $clog2(MAX_TRIES + 1);
    localparam logic [CNT_W-1:0] C_TRY_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TRY_LAST = CNT_W'(MAX_TRIES - 1);
    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] tries_q, tries_d;

    logic [WIDTH-1:0] w_lim_m1;
    logic [WIDTH-1:0] w_smear;
    logic [WIDTH-1:0] w_cand;
    logic             w_in_range;
    logic [WIDTH-1:0] w_fold;
    logic             w_last_try;
    logic             w_accept;
    logic [WIDTH-1:0] w_fallback;

    // Only the low WIDTH bits of the LFSR word take part in sampling.
    generate
        if (RAND_BITS > WIDTH) begin : g_rand_hi
            logic unused_rand_hi;
            assign unused_rand_hi = ^random_i[RAND_BITS-1:WIDTH];
        end
    endgenerate

    // Mask = lim-1 with every bit below its MSB set (smallest 2^k-1 >= lim-1).
    always_comb begin
        w_lim_m1 = lim_q - C_ONE;
        w_smear  = w_lim_m1;
        for (int i = 1; i < WIDTH; i++) begin
            w_smear = w_smear | (w_lim_m1 >> i);
        end
    end

    assign w_cand     = random_i[WIDTH-1:0] & mask_q;
    assign w_in_range = (w_cand < lim_q);
    // cand < 2*lim always, so one subtraction brings it into range.
    assign w_fold     = w_in_range ? w_cand : (w_cand - lim_q);
    assign w_last_try = (tries_q == C_TRY_LAST);

`ifdef RANGE_SAMPLER_NO_REPEAT_EN
    logic prev_vld_q, prev_vld_d;
    logic w_hist_on;

    // History is meaningless for a single-value range, so it only applies when lim > 1.
    assign w_hist_on  = prev_vld_q && (lim_q > C_ONE);
    assign w_accept   = w_in_range && !(w_hist_on && (w_cand == value_q));
    assign w_fallback = (w_hist_on && (w_fold == value_q))
                        ? ((w_fold == w_lim_m1) ? '0 : (w_fold + C_ONE))
                        : w_fold;

    // Previous-output flag: set by the first valid, cleared only by reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_vld_q <= 1'b0;
        end else begin
            prev_vld_q <= prev_vld_d;
        end
    end

    // The flag follows the valid strobe being produced.
    always_comb begin
        prev_vld_d = prev_vld_q | valid_d;
    end
`else
    assign w_accept   = w_in_range;
    assign w_fallback = w_fold;
`endif

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            lim_q   <= C_ONE;
            mask_q  <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            tries_q <= '0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            mask_q  <= mask_d;
            value_q <= value_d;
            valid_q <= valid_d;
            tries_q <= tries_d;
        end
    end

    // Next-state logic: capture in IDLE, build mask in LOAD, draw in SAMPLE.
    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        mask_d  = mask_q;
        value_d = value_q;
        valid_d = 1'b0;
        tries_d = tries_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    lim_d   = (limit_i == '0) ? C_ONE : limit_i;
                    tries_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mask_d  = w_smear;
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                tries_d = tries_q + C_TRY_ONE;
                if (w_accept) begin
                    value_d = w_cand;
                    valid_d = 1'b1;
                    tries_d = '0;
                    state_d = ST_IDLE;
                end else if (w_last_try) begin
                    value_d = w_fallback;
                    valid_d = 1'b1;
                    tries_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign valid_o = valid_q;
    assign value_o = value_q;

endmodule
`default_nettype wire

// File: tb/tb_random_range_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_random_range_sampler
// Description : Directed self-checking bench for random_range_sampler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_random_range_sampler;

    logic        clk_i;
    logic        reset_n_i;
    logic [31:0] random_i;
    logic        req_i;
    logic [7:0]  limit_i;
    logic        busy_o;
    logic        valid_o;
    logic [7:0]  value_o;

    int checks = 0;
    int errors = 0;

    random_range_sampler #(
        .RAND_BITS (32),
        .WIDTH     (8),
        .MAX_TRIES (4)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .random_i  (random_i),
        .req_i     (req_i),
        .limit_i   (limit_i),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .value_o   (value_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request; b0..b3 are the low bytes presented at the 1st..4th SAMPLE edge
    // (b3 repeats afterwards). Optionally re-pulses req while busy.
    task automatic draw(input string tag, input logic [7:0] lim,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        input logic [7:0] exp_val, input int exp_lat,
                        input bit repulse);
        int         lat;
        logic [7:0] b;
        lat = 0;
        @(negedge clk_i);
        req_i    = 1'b1;
        limit_i  = lim;
        random_i = $urandom();
        @(posedge clk_i); #1;
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk_i);
            req_i = repulse && (k == 2);
            if (k == 1) limit_i = 8'($urandom());
            case (k)
                2:       b = b0;
                3:       b = b1;
                4:       b = b2;
                default: b = b3;
            endcase
            random_i      = $urandom();
            random_i[7:0] = b;
            @(posedge clk_i); #1;
            if (valid_o) begin
                lat = k;
                chk({tag, "_value"}, {24'd0, value_o}, {24'd0, exp_val});
                chk({tag, "_busy_at_valid"}, {31'd0, busy_o}, 32'd0);
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    int nvalid;

    initial begin
        reset_n_i = 1'b0;
        req_i     = 1'b0;
        limit_i   = 8'd0;
        random_i  = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Idle after reset: nothing happens without a request.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            random_i = $urandom();
            @(posedge clk_i); #1;
            chk("rst_valid", {31'd0, valid_o}, 32'd0);
            chk("rst_busy",  {31'd0, busy_o},  32'd0);
            chk("rst_value", {24'd0, value_o}, 32'd0);
        end

        // Direct accept, mask 7.
        draw("lim6_direct", 8'd6, 8'h03, 8'h03, 8'h03, 8'h03, 8'd3, 2, 1'b0);
        // limit 0 behaves as 1.
        draw("lim0", 8'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd0, 2, 1'b0);
        // Four rejects then fallback 7-5 = 2.
        draw("lim5_fallback", 8'd5, 8'h07, 8'h07, 8'h07, 8'h07, 8'd2, 5, 1'b0);
        draw("lim1", 8'd1, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'd0, 2, 1'b0);
        // Two rejects (7, 6) then 2.
        draw("lim6_reject2", 8'd6, 8'h07, 8'h0E, 8'h02, 8'h02, 8'd2, 4, 1'b0);

        // Back-to-back draws with the same first sample.
        draw("nr_first", 8'd4, 8'h01, 8'h01, 8'h01, 8'h01, 8'd1, 2, 1'b0);
`ifdef RANGE_SAMPLER_NO_REPEAT_EN
        draw("nr_second", 8'd4, 8'h01, 8'h02, 8'h02, 8'h02, 8'd2, 3, 1'b0);
`else
        draw("nr_second", 8'd4, 8'h01, 8'h02, 8'h02, 8'h02, 8'd1, 2, 1'b0);
`endif

        // Request pulsed again while busy is ignored.
        draw("busy_req", 8'd6, 8'h07, 8'h03, 8'h03, 8'h03, 8'd3, 3, 1'b1);
        nvalid = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i); #1;
            if (valid_o) nvalid++;
        end
        chk("busy_req_no_extra", nvalid, 0);

        // Request held high with limit 8: value = low 3 bits at each SAMPLE edge.
        @(negedge clk_i);
        req_i   = 1'b1;
        limit_i = 8'd8;
        nvalid  = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk_i);
            random_i      = $urandom();
            random_i[2:0] = 3'(k);
            @(posedge clk_i); #1;
            if (valid_o) begin
                nvalid++;
                chk("held_value", {24'd0, value_o}, 32'(k % 8));
                chk("held_busy",  {31'd0, busy_o},  32'd0);
            end
        end
        chk("held_count", nvalid, 6);
        @(negedge clk_i);
        req_i = 1'b0;
        repeat (4) @(posedge clk_i);

        // Reset in the middle of SAMPLE aborts with no valid.
        @(negedge clk_i);
        req_i    = 1'b1;
        limit_i  = 8'd5;
        random_i = 32'h0000_0007;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("midrst_busy",  {31'd0, busy_o},  32'd0);
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        chk("midrst_value", {24'd0, value_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i); #1;
            if (valid_o || busy_o) nvalid++;
        end
        chk("midrst_quiet", nvalid, 0);
        chk("midrst_value_hold", {24'd0, value_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
